// File: rtl/image_crop_pkg.sv
// rtl/image_crop_pkg.sv - shared state type and elaboration helpers for the crop stage
package image_crop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_STREAM,
        ST_DRAIN
    } crop_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit same_data(input int a_w, input int b_w);
        return a_w == b_w;
    endfunction

endpackage

// File: rtl/image_crop_xy_counter.sv
// rtl/image_crop_xy_counter.sv - raster x/y position counter shared by pipe stages
module image_xy_counter
    import image_crop_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 6,
    localparam int XW    = cnt_w(WIDTH),
    localparam int YW    = cnt_w(HEIGHT)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          at_last_o
);

    logic [XW-1:0] x_q, x_d, base_x;
    logic [YW-1:0] y_q, y_d, base_y;

    // clear together with advance means "this pixel is the origin", so step past it
    always_comb begin
        base_x = clear_i ? '0 : x_q;
        base_y = clear_i ? '0 : y_q;
        x_d    = base_x;
        y_d    = base_y;
        if (advance_i) begin
            if (base_x == XW'(WIDTH - 1)) begin
                x_d = '0;
                y_d = (base_y == YW'(HEIGHT - 1)) ? '0 : base_y + YW'(1);
            end else begin
                x_d = base_x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign at_last_o = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));

endmodule

// File: rtl/image_crop.sv
// rtl/image_crop.sv - request-driven pipe stage passing a rectangular window of each frame
module image_crop
    import image_crop_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int IN_HEIGHT  = 6,
    parameter int IN_DATA_W  = 24,
    parameter int OUT_WIDTH  = 8,
    parameter int OUT_HEIGHT = 6,
    parameter int OUT_DATA_W = 24,
    parameter int X0         = 0,
    parameter int Y0         = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_start_i,
    input  logic                  in_stop_i,
    input  logic [IN_DATA_W-1:0]  in_data_i,
    input  logic                  in_valid_i,
    input  logic                  in_error_i,
    output logic                  in_request_o,
    output logic                  in_cancel_o,
    output logic                  in_ready_o,
    output logic                  out_start_o,
    output logic                  out_stop_o,
    output logic [OUT_DATA_W-1:0] out_data_o,
    output logic                  out_valid_o,
    output logic                  out_error_o,
    input  logic                  out_request_i,
    input  logic                  out_cancel_i,
    input  logic                  out_ready_i,
    output logic                  out_sending
);

    localparam int XW = cnt_w(IN_WIDTH);
    localparam int YW = cnt_w(IN_HEIGHT);
    localparam bit ORIGIN_IS_LAST = (IN_WIDTH == 1) && (IN_HEIGHT == 1);

    if (X0 + OUT_WIDTH > IN_WIDTH) begin : g_bad_x
        $fatal(1, "image_crop: X0 + OUT_WIDTH exceeds IN_WIDTH");
    end
    if (Y0 + OUT_HEIGHT > IN_HEIGHT) begin : g_bad_y
        $fatal(1, "image_crop: Y0 + OUT_HEIGHT exceeds IN_HEIGHT");
    end
    if (!same_data(IN_DATA_W, OUT_DATA_W)) begin : g_bad_w
        $fatal(1, "image_crop: input and output data widths differ");
    end

    crop_state_e state_q, state_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  buf_start_q, buf_start_d;
    logic                  buf_stop_q, buf_stop_d;
    logic [OUT_DATA_W-1:0] buf_data_q, buf_data_d;
    logic                  error_q, error_d;
    logic                  in_request_q, in_request_d;

    logic          active, accept, take, origin, keep, last_pos, cnt_at_last;
    logic          cnt_clear, cnt_advance;
    logic [XW-1:0] cnt_x, cx;
    logic [YW-1:0] cnt_y, cy;

    assign active     = (state_q == ST_WAIT_START) || (state_q == ST_STREAM);
    assign in_ready_o = active && (!buf_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    // A Start pixel always sits at the origin, whether it opens the frame or resyncs it
    assign origin     = (state_q == ST_WAIT_START) || in_start_i;
    assign take       = accept && ((state_q == ST_STREAM) || in_start_i);
    assign cx         = origin ? '0 : cnt_x;
    assign cy         = origin ? '0 : cnt_y;
    assign last_pos   = origin ? ORIGIN_IS_LAST : cnt_at_last;
    assign keep       = (int'(cx) >= X0) && (int'(cx) < X0 + OUT_WIDTH) &&
                        (int'(cy) >= Y0) && (int'(cy) < Y0 + OUT_HEIGHT);

    assign cnt_clear   = ((state_q == ST_IDLE) && out_request_i) || out_cancel_i ||
                         (take && origin);
    assign cnt_advance = take && !out_cancel_i;

    image_xy_counter #(
        .WIDTH  (IN_WIDTH),
        .HEIGHT (IN_HEIGHT)
    ) u_xy (
        .clk_i     (clock),
        .rst_ni    (reset),
        .clear_i   (cnt_clear),
        .advance_i (cnt_advance),
        .x_o       (cnt_x),
        .y_o       (cnt_y),
        .at_last_o (cnt_at_last)
    );

    always_comb begin
        state_d      = state_q;
        buf_valid_d  = buf_valid_q;
        buf_start_d  = buf_start_q;
        buf_stop_d   = buf_stop_q;
        buf_data_d   = buf_data_q;
        error_d      = error_q;
        in_request_d = 1'b0;

        if (buf_valid_q && out_ready_i) begin
            buf_valid_d = 1'b0;
            buf_start_d = 1'b0;
            buf_stop_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (out_request_i) begin
                    state_d      = ST_WAIT_START;
                    in_request_d = 1'b1;
                    error_d      = 1'b0;
                end
            end
            ST_WAIT_START, ST_STREAM: begin
                if (take) begin
                    state_d = ST_STREAM;
                    if (keep) begin
                        buf_valid_d = 1'b1;
                        buf_data_d  = in_data_i;
                        buf_start_d = (int'(cx) == X0) && (int'(cy) == Y0);
                        buf_stop_d  = (int'(cx) == X0 + OUT_WIDTH - 1) &&
                                      (int'(cy) == Y0 + OUT_HEIGHT - 1);
                    end
                    if (in_error_i || ((state_q == ST_STREAM) && in_start_i)) begin
                        error_d = 1'b1;
                    end
                    // Stop early or a missing Stop at the last position both flag the frame
                    if (in_stop_i != last_pos) begin
                        error_d = 1'b1;
                    end
                    if (in_stop_i || last_pos) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!buf_valid_q || out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (out_cancel_i) begin
            state_d      = ST_IDLE;
            buf_valid_d  = 1'b0;
            buf_start_d  = 1'b0;
            buf_stop_d   = 1'b0;
            buf_data_d   = '0;
            error_d      = 1'b0;
            in_request_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            buf_valid_q  <= 1'b0;
            buf_start_q  <= 1'b0;
            buf_stop_q   <= 1'b0;
            buf_data_q   <= '0;
            error_q      <= 1'b0;
            in_request_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_valid_q  <= buf_valid_d;
            buf_start_q  <= buf_start_d;
            buf_stop_q   <= buf_stop_d;
            buf_data_q   <= buf_data_d;
            error_q      <= error_d;
            in_request_q <= in_request_d;
        end
    end

    assign in_request_o = in_request_q;
    assign in_cancel_o  = out_cancel_i;
    assign out_valid_o  = buf_valid_q;
    assign out_start_o  = buf_start_q;
    assign out_stop_o   = buf_stop_q;
    assign out_data_o   = buf_data_q;
    assign out_error_o  = error_q;
    assign out_sending  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_image_crop.sv
// tb/tb_image_crop.sv - directed bench for image_crop, 8x6 source cropped 4x3 at (2,1) and identity
module tb_image_crop;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_start = 1'b0, in_stop = 1'b0, in_valid = 1'b0, in_error = 1'b0;
    logic [23:0] in_data = '0;
    logic        out_request = 1'b0, out_cancel = 1'b0, out_ready = 1'b1;
    logic        sel = 1'b0;

    logic        cr_in_request, cr_in_cancel, cr_in_ready, cr_out_start, cr_out_stop;
    logic        cr_out_valid, cr_out_error, cr_sending;
    logic [23:0] cr_out_data;
    logic        id_in_request, id_in_cancel, id_in_ready, id_out_start, id_out_stop;
    logic        id_out_valid, id_out_error, id_sending;
    logic [23:0] id_out_data;

    logic        m_in_request, m_in_cancel, m_in_ready, m_out_start, m_out_stop;
    logic        m_out_valid, m_out_error, m_sending;
    logic [23:0] m_out_data;

    image_crop #(
        .IN_WIDTH(8), .IN_HEIGHT(6), .IN_DATA_W(24),
        .OUT_WIDTH(4), .OUT_HEIGHT(3), .OUT_DATA_W(24), .X0(2), .Y0(1)
    ) u_crop (
        .clock(clk), .reset(rst_n),
        .in_start_i(in_start), .in_stop_i(in_stop), .in_data_i(in_data),
        .in_valid_i(in_valid), .in_error_i(in_error),
        .in_request_o(cr_in_request), .in_cancel_o(cr_in_cancel), .in_ready_o(cr_in_ready),
        .out_start_o(cr_out_start), .out_stop_o(cr_out_stop), .out_data_o(cr_out_data),
        .out_valid_o(cr_out_valid), .out_error_o(cr_out_error),
        .out_request_i(out_request && !sel), .out_cancel_i(out_cancel), .out_ready_i(out_ready),
        .out_sending(cr_sending)
    );

    image_crop #(
        .IN_WIDTH(8), .IN_HEIGHT(6), .IN_DATA_W(24),
        .OUT_WIDTH(8), .OUT_HEIGHT(6), .OUT_DATA_W(24), .X0(0), .Y0(0)
    ) u_ident (
        .clock(clk), .reset(rst_n),
        .in_start_i(in_start), .in_stop_i(in_stop), .in_data_i(in_data),
        .in_valid_i(in_valid), .in_error_i(in_error),
        .in_request_o(id_in_request), .in_cancel_o(id_in_cancel), .in_ready_o(id_in_ready),
        .out_start_o(id_out_start), .out_stop_o(id_out_stop), .out_data_o(id_out_data),
        .out_valid_o(id_out_valid), .out_error_o(id_out_error),
        .out_request_i(out_request && sel), .out_cancel_i(out_cancel), .out_ready_i(out_ready),
        .out_sending(id_sending)
    );

    assign m_in_request = sel ? id_in_request : cr_in_request;
    assign m_in_cancel  = sel ? id_in_cancel  : cr_in_cancel;
    assign m_in_ready   = sel ? id_in_ready   : cr_in_ready;
    assign m_out_start  = sel ? id_out_start  : cr_out_start;
    assign m_out_stop   = sel ? id_out_stop   : cr_out_stop;
    assign m_out_data   = sel ? id_out_data   : cr_out_data;
    assign m_out_valid  = sel ? id_out_valid  : cr_out_valid;
    assign m_out_error  = sel ? id_out_error  : cr_out_error;
    assign m_sending    = sel ? id_sending    : cr_sending;

    int n_tests = 0;
    int n_fail  = 0;
    int got_data[$];
    bit got_start[$];
    bit got_stop[$];
    int crop_exp[12] = '{10, 11, 12, 13, 18, 19, 20, 21, 26, 27, 28, 29};

    typedef struct {
        bit use_ident;
        bit toggle;
        int stop_at;
        bit exp_err;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit keep_px(input int p);
        int x, y;
        x = p % 8;
        y = p / 8;
        if (sel) return 1'b1;
        return (x >= 2) && (x < 6) && (y >= 1) && (y < 4);
    endfunction

    task automatic request_frame();
        @(posedge clk); #1;
        out_request = 1'b1;
        in_valid    = 1'b0;
        @(posedge clk); #1;
        out_request = 1'b0;
        @(negedge clk);
        check("req_pulse_hi", m_in_request, 1);
        check("sending_hi", m_sending, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("req_pulse_lo", m_in_request, 0);
    endtask

    task automatic run_frame(input bit toggle, input int stop_at, input int cancel_at,
                             input int reset_at);
        int p;
        int drain;
        int prev_data;
        bit prev_keep;
        got_data.delete();
        got_start.delete();
        got_stop.delete();
        request_frame();
        p = 0;
        drain = -1;
        prev_keep = 1'b0;
        prev_data = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            in_valid  = (p <= stop_at);
            in_data   = 24'(p);
            in_start  = (p == 0);
            in_stop   = (p == stop_at);
            in_error  = 1'b0;
            out_ready = toggle ? ~out_ready : 1'b1;
            if (p == cancel_at) begin
                in_valid   = 1'b0;
                out_cancel = 1'b1;
                @(negedge clk);
                check("cancel_passthru", m_in_cancel, 1);
                @(posedge clk); #1;
                out_cancel = 1'b0;
                @(negedge clk);
                check("cancel_valid", m_out_valid, 0);
                check("cancel_sending", m_sending, 0);
                return;
            end
            if (p == reset_at) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_valid", m_out_valid, 0);
                check("rst_start", m_out_start, 0);
                check("rst_stop", m_out_stop, 0);
                check("rst_error", m_out_error, 0);
                check("rst_sending", m_sending, 0);
                in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (prev_keep) begin
                check("latency_valid", m_out_valid, 1);
                check("latency_data", m_out_data, prev_data);
            end
            if (m_out_valid && out_ready) begin
                got_data.push_back(int'(m_out_data));
                got_start.push_back(m_out_start);
                got_stop.push_back(m_out_stop);
            end
            prev_keep = 1'b0;
            if (p <= stop_at) begin
                check("in_ready_rule", m_in_ready, !m_out_valid || out_ready);
                if (m_in_ready) begin
                    prev_keep = keep_px(p);
                    prev_data = p;
                    if (p == stop_at) drain = 0;
                    p++;
                end
            end else begin
                drain++;
                if (!m_sending) break;
            end
        end
        if (!toggle) check("drain_cycles_le2", (drain >= 0) && (drain <= 2), 1);
        check("frame_done", m_sending, 0);
    endtask

    task automatic check_frame(input bit exp_err);
        int n;
        int exp;
        n = sel ? 48 : 12;
        check("pixel_count", got_data.size(), n);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            exp = sel ? i : crop_exp[i];
            check("pixel_data", got_data[i], exp);
            check("pixel_start", got_start[i], i == 0);
            check("pixel_stop", got_stop[i], i == n - 1);
        end
        check("frame_error", m_out_error, exp_err);
    endtask

    initial begin
        vecs[0] = '{use_ident: 1'b0, toggle: 1'b0, stop_at: 47, exp_err: 1'b0};
        vecs[1] = '{use_ident: 1'b0, toggle: 1'b1, stop_at: 47, exp_err: 1'b0};
        vecs[2] = '{use_ident: 1'b1, toggle: 1'b0, stop_at: 47, exp_err: 1'b0};
        vecs[3] = '{use_ident: 1'b0, toggle: 1'b0, stop_at: 30, exp_err: 1'b1};
        vecs[4] = '{use_ident: 1'b0, toggle: 1'b1, stop_at: 30, exp_err: 1'b1};

        #2;
        check("reset_valid", m_out_valid, 0);
        check("reset_sending", m_sending, 0);
        check("reset_request", m_in_request, 0);
        check("reset_error", m_out_error, 0);
        check("reset_data", m_out_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            sel = vecs[v].use_ident;
            out_ready = 1'b1;
            run_frame(vecs[v].toggle, vecs[v].stop_at, -1, -1);
            check_frame(vecs[v].exp_err);
        end

        sel = 1'b0;
        out_ready = 1'b1;
        run_frame(1'b0, 47, 20, -1);
        run_frame(1'b0, 47, -1, -1);
        check_frame(1'b0);

        out_ready = 1'b1;
        run_frame(1'b0, 47, -1, 15);
        run_frame(1'b0, 47, -1, -1);
        check_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_crop.md
Name: image_crop

Overview:
- Pipe stage directly downstream of the image background generator and other image sources.
- Consumes a full frame on `image_in` and emits only the rectangular window of size Out width × Out height whose top-left corner is at (X0, Y0).
- It is request-driven: a downstream request starts one upstream frame, and cancel propagates upstream.
- A single output register stage carries the window pixels; all other pixels are accepted and dropped.

Parameters:
- IS_In, `IS_DEFAULT, spec of the incoming image pipe (width, height, format, data width).
- IS_Out, `IS_DEFAULT, spec of the outgoing pipe. Width/height give the crop size; format and data width must equal those of IS_In.
- X0, 0, left column of the window in input coordinates.
- Y0, 0, top row of the window in input coordinates.

Ports:
- clock  input  1  single clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- image_in  inout  `I_w(IS_In)  sink side. Block drives Request, Cancel, Ready; reads Start, Stop, Data, Valid, Error.
- image_out  inout  `I_w(IS_Out)  source side. Block drives Start, Stop, Data, Valid, Error; reads Request, Cancel, Ready.
- out_sending  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset low, async assert, sync-released logic):
  - state=IDLE, in_x=in_y=0, buffered Valid/Start/Stop/Error=0, Data=0, in_request=0.
- Elaboration checks (fatal on violation):
  - X0 + OutWidth <= InWidth.
  - Y0 + OutHeight <= InHeight.
  - Data widths of IS_In and IS_Out equal.
- States:
  - IDLE → on out_request: pulse in_request for exactly 1 cycle; go to WAIT_START.
  - WAIT_START: in_ready=1; non-Start pixels are accepted and discarded. On an accepted pixel with Start=1: in_x,in_y=0, processed as pixel (0,0); go to STREAM.
  - STREAM: normal streaming (rules below).
  - DRAIN: after the last input pixel is accepted. Wait until the output register is empty (or accepted); then go to IDLE.
- Accept/handshake:
  - accept = in_valid && in_ready.
  - in_ready = !buf_valid || out_ready (combinational).
  - Output pipe: buf_valid holds until out_ready is sampled high.
- Keep test: X0 <= in_x < X0+OutWidth and Y0 <= in_y < Y0+OutHeight.
  - Kept pixel on accept: buf_data=in_data, buf_valid=1, out_start=(in_x==X0 && in_y==Y0), out_stop=(in_x==X0+OutWidth-1 && in_y==Y0+OutHeight-1).
  - Dropped pixel: consumes a cycle. It loads nothing, and buf_valid clears if out_ready was high.
  - Latency: kept pixel appears on image_out 1 cycle after accept.
- Counter update on accept:
  - in_x++. If in_x==InWidth-1, then in_x=0 and in_y++.
  - The pixel at (InWidth-1, InHeight-1), or any in_stop accept, ends the frame → DRAIN.
- Error rules (out_error sticky until next IDLE→WAIT_START):
  - Set on in_error accepted.
  - Set on Start accepted in STREAM. The counters resync to (0,0) and that pixel is treated as (0,0).
  - Set on in_stop accepted at a position other than (InWidth-1, InHeight-1); go to DRAIN.
  - Set on reaching the last position without in_stop; go to DRAIN anyway.
- Cancel:
  - in_cancel = out_cancel (combinational).
  - On out_cancel the block synchronously returns to reset values, same as reset, except the asynchrony.
- Simultaneous events:
  - out_request while not IDLE is ignored.
  - Same cycle accept and out_ready with buf_valid: the buffer is replaced, with no bubble.
- Reset mid-frame: all outputs are immediately the reset values. The upstream is not cancelled; the next request restarts at WAIT_START.

Decomposition:
- Shared package (existing image_defs.v):
  - IS field macros, `I_*` pipe accessors, format constants.
  - Add `IS_SAME_DATA(a,b)` helper for the width check.
- One natural sub-module: image_xy_counter.
  - Parameters: Width, Height.
  - Inputs: clear, advance.
  - Outputs: x, y, at_last.
  - Reusable by other pipe stages.

Test Plan:
- Common setup: IS_In 8×6 RGB, crop 4×3 at (2,1). Source emits data = y*8+x; out_ready=1.
  - One request → 12 pixels out: 10,11,12,13,18…21,26…29. Start only on 10, Stop only on 29; out_sending falls within 2 cycles after the last input; no error.
- Same frame, out_ready toggled 1/0 every cycle → same 12 values in order, none duplicated or lost. in_ready low only while the buffer is full and out_ready=0.
- Crop 8×6 at (0,0) → identity: 48 pixels 0…47, Start on 0, Stop on 47, 1-cycle latency.
- out_cancel asserted after the 20th input pixel:
  - in_cancel same cycle.
  - Next cycle: out_valid=0, out_sending=0.
  - A new request produces the full 12-pixel sequence again.
- Source asserts Stop at pixel 30 (short frame) → out_error=1, outputs 10…29 complete, then the block returns to IDLE.
- reset low during pixel 15 → out_valid/start/stop/error=0 asynchronously. After release, a request yields a clean 12-pixel frame.
